// File: rtl/axi4_pkg.sv
// Shared AXI4 channel structs, sized for the widest manager in the system.
// Narrower users zero-extend and ignore the upper lanes.
package axi4_pkg;

  localparam int unsigned AXI_ID_W   = 8;
  localparam int unsigned AXI_ADDR_W = 64;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  // Address channel, shared by AW and AR
  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  valid;
  } axi_ax_m_t;

  typedef struct packed {
    logic ready;
  } axi_ready_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
    logic                  valid;
  } axi_w_m_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
    logic                valid;
  } axi_b_s_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic                  valid;
  } axi_r_s_t;

endpackage

// File: rtl/riscv_axi_master_pkg.sv
// Types and constants for the core memory-port AXI master and its reorder buffer.
package riscv_axi_master_pkg;
  import axi4_pkg::*;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef struct packed {
    logic                  alloc;
    logic                  rnw;
    logic [AXI_ADDR_W-1:0] addr;
    logic                  rsp_vld;
    logic                  err;
    logic [AXI_DATA_W-1:0] data;
  } rob_entry_t;

  function automatic logic [2:0] size_for(input int unsigned data_w);
    return (data_w == 64) ? 3'd3 : 3'd2;
  endfunction

endpackage

// File: rtl/riscv_axi_rob.sv
// Reorder buffer indexed by AXI ID: allocates in request order, captures R/B
// responses in any order and presents them back at the head in request order.
module riscv_axi_rob
  import axi4_pkg::*;
  import riscv_axi_master_pkg::*;
#(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  alloc,
  input  logic                  alloc_rnw,
  input  logic [ADDR_W-1:0]     alloc_addr,
  output logic [ID_W-1:0]       alloc_id,
  output logic                  full,
  input  logic                  r_vld,
  input  logic [AXI_ID_W-1:0]   r_id,
  input  logic [AXI_DATA_W-1:0] r_data,
  input  logic                  r_err,
  input  logic                  b_vld,
  input  logic [AXI_ID_W-1:0]   b_id,
  input  logic                  b_err,
  output logic                  rsp_vld,
  output logic                  rsp_rnw,
  output logic [ADDR_W-1:0]     rsp_addr,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_err,
  input  logic                  rsp_ack,
  output logic                  err_unexp
);

  localparam int unsigned DEPTH = 2 ** ID_W;
  localparam int unsigned PTR_W = ID_W + 1;

  rob_entry_t       entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ID_W-1:0]  wr_idx, rd_idx, r_idx, b_idx;
  logic             empty, free;
  logic             r_ok, b_ok, r_cap, b_cap;
  rob_entry_t       head;
  logic             unused_head;

  assign wr_idx   = wr_ptr_q[ID_W-1:0];
  assign rd_idx   = rd_ptr_q[ID_W-1:0];
  assign full     = (wr_ptr_q[ID_W] != rd_ptr_q[ID_W]) && (wr_idx == rd_idx);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign alloc_id = wr_idx;

  // IDs with bits above ID_W can never be pending
  assign r_idx = r_id[ID_W-1:0];
  assign b_idx = b_id[ID_W-1:0];
  assign r_ok  = ((r_id >> ID_W) == '0) && entries[r_idx].alloc && !entries[r_idx].rsp_vld;
  assign b_ok  = ((b_id >> ID_W) == '0) && entries[b_idx].alloc && !entries[b_idx].rsp_vld &&
                 !(r_cap && (r_idx == b_idx));
  assign r_cap = r_vld && r_ok;
  assign b_cap = b_vld && b_ok;

  assign head     = entries[rd_idx];
  assign rsp_vld  = head.rsp_vld && !empty;
  assign rsp_rnw  = rsp_vld && head.rnw;
  assign rsp_err  = rsp_vld && head.err;
  assign rsp_addr = rsp_vld ? head.addr[ADDR_W-1:0] : '0;
  assign rsp_data = rsp_vld ? head.data[DATA_W-1:0] : '0;
  assign free     = rsp_vld && rsp_ack;

  // Upper address/data lanes beyond ADDR_W/DATA_W are never populated
  assign unused_head = ^head;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_unexp <= 1'b0;
    end else begin
      if (alloc) begin
        entries[wr_idx] <= '{alloc: 1'b1, rnw: alloc_rnw, addr: AXI_ADDR_W'(alloc_addr),
                             rsp_vld: 1'b0, err: 1'b0, data: '0};
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (r_cap) begin
        entries[r_idx].rsp_vld <= 1'b1;
        entries[r_idx].data    <= r_data;
        entries[r_idx].err     <= r_err;
      end
      if (b_cap) begin
        entries[b_idx].rsp_vld <= 1'b1;
        entries[b_idx].err     <= b_err;
      end
      if (free) begin
        entries[rd_idx].alloc   <= 1'b0;
        entries[rd_idx].rsp_vld <= 1'b0;
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if ((r_vld && !r_ok) || (b_vld && !b_ok)) err_unexp <= 1'b1;
    end
  end

endmodule

// File: rtl/riscv_axi_master.sv
// In-order AXI4 master for the core memory port: single-beat reads on AR,
// writes on AW+W, responses returned in request order through the ROB.
module riscv_axi_master
  import axi4_pkg::*;
  import riscv_axi_master_pkg::*;
#(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_vld,
  input  logic                req_rnw,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  input  logic [DATA_W/8-1:0] req_strb,
  output logic                req_ack,
  output logic                rsp_vld,
  output logic                rsp_rnw,
  output logic [ADDR_W-1:0]   rsp_addr,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  input  logic                rsp_ack,
  output logic                err_unexp,
  input  axi_ready_t          AXI_AW_S,
  input  axi_ready_t          AXI_W_S,
  input  axi_b_s_t            AXI_B_S,
  input  axi_ready_t          AXI_AR_S,
  input  axi_r_s_t            AXI_R_S,
  output axi_ax_m_t           AXI_AW_M,
  output axi_w_m_t            AXI_W_M,
  output axi_ready_t          AXI_B_M,
  output axi_ax_m_t           AXI_AR_M,
  output axi_ready_t          AXI_R_M
);

  logic            run_q, aw_done_q, w_done_q;
  logic            full, issue_ok;
  logic            ar_valid, aw_valid, w_valid;
  logic            ar_hs, aw_hs, w_hs, wr_ack;
  logic [ID_W-1:0] alloc_id;
  logic            unused_rlast;

  // run_q holds all VALIDs low until the first edge after reset release
  assign issue_ok = run_q && req_vld && !full;
  assign ar_valid = issue_ok && req_rnw;
  assign aw_valid = issue_ok && !req_rnw && !aw_done_q;
  assign w_valid  = issue_ok && !req_rnw && !w_done_q;

  assign ar_hs  = ar_valid && AXI_AR_S.ready;
  assign aw_hs  = aw_valid && AXI_AW_S.ready;
  assign w_hs   = w_valid && AXI_W_S.ready;
  assign wr_ack = issue_ok && !req_rnw && (aw_done_q || aw_hs) && (w_done_q || w_hs);

  assign req_ack      = ar_hs || wr_ack;
  assign unused_rlast = AXI_R_S.last;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (wr_ack) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        aw_done_q <= aw_done_q || aw_hs;
        w_done_q  <= w_done_q || w_hs;
      end
    end
  end

  always_comb begin
    AXI_AR_M       = '0;
    AXI_AR_M.valid = ar_valid;
    AXI_AR_M.id    = AXI_ID_W'(alloc_id);
    AXI_AR_M.addr  = AXI_ADDR_W'(req_addr);
    AXI_AR_M.size  = size_for(DATA_W);
    AXI_AR_M.burst = BURST_INCR;

    AXI_AW_M       = AXI_AR_M;
    AXI_AW_M.valid = aw_valid;

    AXI_W_M       = '0;
    AXI_W_M.valid = w_valid;
    AXI_W_M.data  = AXI_DATA_W'(req_data);
    AXI_W_M.strb  = AXI_STRB_W'(req_strb);
    AXI_W_M.last  = 1'b1;

    AXI_B_M.ready = 1'b1;
    AXI_R_M.ready = 1'b1;
  end

  riscv_axi_rob #(
    .ID_W  (ID_W),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rob (
    .clock     (clock),
    .reset_n   (reset_n),
    .alloc     (req_ack),
    .alloc_rnw (req_rnw),
    .alloc_addr(req_addr),
    .alloc_id  (alloc_id),
    .full      (full),
    .r_vld     (AXI_R_S.valid),
    .r_id      (AXI_R_S.id),
    .r_data    (AXI_R_S.data),
    .r_err     (AXI_R_S.resp != RESP_OKAY),
    .b_vld     (AXI_B_S.valid),
    .b_id      (AXI_B_S.id),
    .b_err     (AXI_B_S.resp != RESP_OKAY),
    .rsp_vld   (rsp_vld),
    .rsp_rnw   (rsp_rnw),
    .rsp_addr  (rsp_addr),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_ack   (rsp_ack),
    .err_unexp (err_unexp)
  );

endmodule

// File: tb/tb_riscv_axi_master.sv
// Self-checking bench for riscv_axi_master with a 4-deep ROB: vector table plus
// hand-written reorder, full/wrap, unexpected-ID and mid-write reset sequences.
module tb_riscv_axi_master;
  import axi4_pkg::*;

  localparam int unsigned ID_W   = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 2 ** ID_W;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_vld, req_rnw, req_ack;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [3:0]        req_strb;
  logic              rsp_vld, rsp_rnw, rsp_err, rsp_ack, err_unexp;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  axi_ready_t        aw_s, w_s, ar_s, b_m, r_m;
  axi_b_s_t          b_s;
  axi_r_s_t          r_s;
  axi_ax_m_t         aw_m, ar_m;
  axi_w_m_t          w_m;

  typedef struct packed {
    logic              rnw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  typedef struct packed {
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  rsp_t        sb[$];
  rsp_t        mon_exp;
  vec_t        vecs[6];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned exp_id;

  riscv_axi_master #(
    .ID_W  (ID_W),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_vld  (req_vld),
    .req_rnw  (req_rnw),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_strb (req_strb),
    .req_ack  (req_ack),
    .rsp_vld  (rsp_vld),
    .rsp_rnw  (rsp_rnw),
    .rsp_addr (rsp_addr),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .rsp_ack  (rsp_ack),
    .err_unexp(err_unexp),
    .AXI_AW_S (aw_s),
    .AXI_W_S  (w_s),
    .AXI_B_S  (b_s),
    .AXI_AR_S (ar_s),
    .AXI_R_S  (r_s),
    .AXI_AW_M (aw_m),
    .AXI_W_M  (w_m),
    .AXI_B_M  (b_m),
    .AXI_AR_M (ar_m),
    .AXI_R_M  (r_m)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish within 100us");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every returned response must match the oldest accepted request
  always @(negedge clock) begin
    if (reset_n === 1'b1 && rsp_vld === 1'b1 && rsp_ack === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_extra: got response addr 0x%0h, expected none", rsp_addr);
      end else begin
        mon_exp = sb.pop_front();
        check("rsp", {rsp_rnw, rsp_addr, rsp_data, rsp_err}, mon_exp);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clock);
  endtask

  task automatic set_r(input int unsigned id, input logic [31:0] data, input logic [1:0] resp);
    r_s = '{id: AXI_ID_W'(id), data: AXI_DATA_W'(data), resp: resp, last: 1'b1, valid: 1'b1};
  endtask

  task automatic set_b(input int unsigned id, input logic [1:0] resp);
    b_s = '{id: AXI_ID_W'(id), resp: resp, valid: 1'b1};
  endtask

  task automatic idle_inputs();
    req_vld = 1'b0; req_rnw = 1'b0; req_addr = '0; req_data = '0; req_strb = '0;
    aw_s = '0; w_s = '0; ar_s = '0; r_s = '0; b_s = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) cyc();
    sb.delete();
    reset_n = 1'b1;
    repeat (2) cyc();
    exp_id = 0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      cyc();
      n++;
    end
    check(name, 128'(sb.size()), 128'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h1000_0000, 32'h0,         4'h0, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0};
    vecs[1] = '{1'b0, 32'h1000_0004, 32'hA5A5_5A5A, 4'h3, 32'h0,         2'b00, 32'h0,         1'b0};
    vecs[2] = '{1'b1, 32'h2000_0008, 32'h0,         4'h0, 32'hFFFF_0000, 2'b10, 32'hFFFF_0000, 1'b1};
    vecs[3] = '{1'b0, 32'h3000_000C, 32'h0,         4'h8, 32'h0,         2'b11, 32'h0,         1'b1};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0000_0001, 2'b01, 32'h0000_0001, 1'b1};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b00, 32'h0,         1'b0};

    rsp_ack = 1'b1;
    exp_id  = 0;
    idle_inputs();
    req_vld = 1'b1;
    req_rnw = 1'b1;
    reset_n = 1'b0;
    #2;
    check("reset_valids", {ar_m.valid, aw_m.valid, w_m.valid, req_ack}, 4'b0000);
    check("reset_rsp", {rsp_vld, err_unexp}, 2'b00);
    check("readies", {r_m.ready, b_m.ready}, 2'b11);
    apply_reset();

    // Read, R two cycles after acceptance
    req_vld = 1'b1; req_rnw = 1'b1; req_addr = 32'h1000; ar_s.ready = 1'b1;
    at_sample();
    check("rd_ack", req_ack, 1'b1);
    check("rd_ar", {ar_m.valid, ar_m.id, ar_m.len, ar_m.size, ar_m.burst},
          {1'b1, 8'd0, 8'd0, 3'd2, 2'b01});
    sb.push_back('{1'b1, 32'h1000, 32'hDEAD_BEEF, 1'b0});
    cyc();
    req_vld = 1'b0; ar_s.ready = 1'b0;
    cyc();
    set_r(0, 32'hDEAD_BEEF, 2'b00);
    at_sample();
    check("rd_rsp_early", rsp_vld, 1'b0);
    cyc();
    r_s = '0;
    at_sample();
    check("rd_rsp_vld", rsp_vld, 1'b1);
    cyc();
    exp_id = 1;

    // Write: AW accepted in cycle 0, W only in cycle 2
    req_vld = 1'b1; req_rnw = 1'b0; req_addr = 32'h2000; req_data = 32'hCAFE_F00D;
    req_strb = 4'hF; aw_s.ready = 1'b1; w_s.ready = 1'b0;
    at_sample();
    check("wr_c0", {aw_m.valid, w_m.valid, req_ack}, 3'b110);
    check("wr_awid", aw_m.id, 8'(exp_id));
    cyc();
    aw_s.ready = 1'b0;
    at_sample();
    check("wr_c1", {aw_m.valid, w_m.valid, req_ack}, 3'b010);
    cyc();
    w_s.ready = 1'b1;
    at_sample();
    check("wr_c2", {aw_m.valid, w_m.valid, req_ack}, 3'b011);
    check("wr_wbeat", {w_m.data, w_m.strb, w_m.last}, {64'hCAFE_F00D, 8'h0F, 1'b1});
    sb.push_back('{1'b0, 32'h2000, 32'h0, 1'b0});
    cyc();
    req_vld = 1'b0; w_s.ready = 1'b0;
    set_b(exp_id, 2'b00);
    at_sample();
    check("wr_idle", {aw_m.valid, w_m.valid}, 2'b00);
    cyc();
    b_s = '0;
    at_sample();
    check("wr_rsp_vld", rsp_vld, 1'b1);
    cyc();
    exp_id = (exp_id + 1) % DEPTH;

    // Vector table, all readies high, response right after acceptance
    for (int i = 0; i < 6; i++) begin
      req_vld = 1'b1; req_rnw = vecs[i].rnw; req_addr = vecs[i].addr;
      req_data = vecs[i].wdata; req_strb = vecs[i].strb;
      ar_s.ready = 1'b1; aw_s.ready = 1'b1; w_s.ready = 1'b1;
      at_sample();
      check("vec_ack", req_ack, 1'b1);
      if (vecs[i].rnw) begin
        check("vec_ar", {ar_m.valid, aw_m.valid, w_m.valid, ar_m.id, ar_m.addr},
              {3'b100, 8'(exp_id), 64'(vecs[i].addr)});
      end else begin
        check("vec_aw", {ar_m.valid, aw_m.valid, w_m.valid, aw_m.id, aw_m.addr},
              {3'b011, 8'(exp_id), 64'(vecs[i].addr)});
        check("vec_w", {w_m.data, w_m.strb, w_m.last},
              {64'(vecs[i].wdata), 8'(vecs[i].strb), 1'b1});
      end
      sb.push_back('{vecs[i].rnw, vecs[i].addr, vecs[i].exp_data, vecs[i].exp_err});
      cyc();
      req_vld = 1'b0; ar_s.ready = 1'b0; aw_s.ready = 1'b0; w_s.ready = 1'b0;
      if (vecs[i].rnw) set_r(exp_id, vecs[i].rdata, vecs[i].resp);
      else set_b(exp_id, vecs[i].resp);
      cyc();
      r_s = '0; b_s = '0;
      at_sample();
      check("vec_rsp_vld", rsp_vld, 1'b1);
      cyc();
      exp_id = (exp_id + 1) % DEPTH;
    end
    wait_drain("drain_vec");

    // Four reads, R returned 3,1,2,0, emitted 0..3
    apply_reset();
    req_vld = 1'b1; req_rnw = 1'b1; ar_s.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'h100 + 32'(4 * i);
      at_sample();
      check("ro_ack", {req_ack, ar_m.id}, {1'b1, 8'(i)});
      sb.push_back('{1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0});
      cyc();
    end
    req_vld = 1'b0; ar_s.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int unsigned ids[3] = '{3, 1, 2};
      set_r(ids[k], 32'hA000_0000 + ids[k], 2'b00);
      at_sample();
      check("ro_hold", rsp_vld, 1'b0);
      cyc();
    end
    set_r(0, 32'hA000_0000, 2'b00);
    at_sample();
    check("ro_zero_fields", {rsp_vld, rsp_rnw, rsp_addr, rsp_data, rsp_err}, 67'd0);
    cyc();
    r_s = '0;
    for (int i = 0; i < 4; i++) begin
      at_sample();
      check("ro_emit", {rsp_vld, rsp_addr}, {1'b1, 32'h100 + 32'(4 * i)});
      cyc();
    end
    at_sample();
    check("ro_done", rsp_vld, 1'b0);
    cyc();
    wait_drain("drain_ro");

    // Fill all four entries; fifth stalls until the head is freed, then wraps to ID 0
    apply_reset();
    req_vld = 1'b1; req_rnw = 1'b1; ar_s.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'h400 + 32'(4 * i);
      at_sample();
      check("full_ack", req_ack, 1'b1);
      sb.push_back('{1'b1, 32'h400 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0});
      cyc();
    end
    req_addr = 32'h500;
    at_sample();
    check("full_stall0", {ar_m.valid, req_ack}, 2'b00);
    cyc();
    set_r(0, 32'hB000_0000, 2'b00);
    at_sample();
    check("full_stall1", {ar_m.valid, req_ack}, 2'b00);
    cyc();
    r_s = '0;
    at_sample();
    check("full_head", {rsp_vld, ar_m.valid}, 2'b10);
    cyc();
    at_sample();
    check("full_wrap", {ar_m.valid, req_ack, ar_m.id, ar_m.addr}, {2'b11, 8'd0, 64'h500});
    sb.push_back('{1'b1, 32'h500, 32'hB000_0005, 1'b0});
    cyc();
    req_vld = 1'b0; ar_s.ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int unsigned id;
      id = (k + 1) % DEPTH;
      set_r(id, (id == 0) ? 32'hB000_0005 : 32'hB000_0000 + id, 2'b00);
      cyc();
    end
    r_s = '0;
    wait_drain("drain_full");

    // Unexpected RID, then a write answered with SLVERR
    apply_reset();
    set_r(5, 32'h0, 2'b00);
    at_sample();
    check("unexp_before", err_unexp, 1'b0);
    cyc();
    r_s = '0;
    at_sample();
    check("unexp_set", {err_unexp, rsp_vld}, 2'b10);
    repeat (3) cyc();
    at_sample();
    check("unexp_sticky", err_unexp, 1'b1);
    cyc();
    req_vld = 1'b1; req_rnw = 1'b0; req_addr = 32'h6000; req_data = 32'h5555_AAAA;
    req_strb = 4'hF; aw_s.ready = 1'b1; w_s.ready = 1'b1;
    at_sample();
    check("slverr_ack", {req_ack, aw_m.id}, {1'b1, 8'd0});
    sb.push_back('{1'b0, 32'h6000, 32'h0, 1'b1});
    cyc();
    req_vld = 1'b0; aw_s.ready = 1'b0; w_s.ready = 1'b0;
    set_b(0, 2'b10);
    cyc();
    b_s = '0;
    wait_drain("drain_slverr");
    at_sample();
    check("unexp_kept", err_unexp, 1'b1);
    cyc();

    // Reset between the AW and W handshakes of a write
    apply_reset();
    req_vld = 1'b1; req_rnw = 1'b0; req_addr = 32'h7000; req_data = 32'h1111_2222;
    req_strb = 4'hF; aw_s.ready = 1'b1; w_s.ready = 1'b0;
    at_sample();
    check("mid_aw", {aw_m.valid, req_ack}, 2'b10);
    cyc();
    aw_s.ready = 1'b0;
    at_sample();
    check("mid_w", {aw_m.valid, w_m.valid}, 2'b01);
    reset_n = 1'b0;
    #1;
    check("mid_reset", {ar_m.valid, aw_m.valid, w_m.valid, rsp_vld, req_ack}, 5'b00000);
    cyc();
    cyc();
    reset_n = 1'b1;
    exp_id = 0;
    aw_s.ready = 1'b1; w_s.ready = 1'b1;
    cyc();
    at_sample();
    check("post_reset", {aw_m.valid, w_m.valid, req_ack, aw_m.id}, {3'b111, 8'd0});
    sb.push_back('{1'b0, 32'h7000, 32'h0, 1'b0});
    cyc();
    req_vld = 1'b0; aw_s.ready = 1'b0; w_s.ready = 1'b0;
    set_b(0, 2'b00);
    cyc();
    b_s = '0;
    wait_drain("drain_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
